// File: rtl/reset_sequencer_ctrl.sv
// reset_sequencer_ctrl: waits for PLL lock, holds, then releases domain resets in index order.
// Define RESET_SEQ_LOSS_CNT_EN to add the saturating lock_loss_count output.
module reset_sequencer_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 256,
  parameter int GAP_CYCLES  = 16,
  parameter int LOCK_SYNC   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pll_locked,
  input  logic                 sw_reset_req,
  output logic [N_DOMAINS-1:0] domain_reset,
  output logic                 all_released,
`ifdef RESET_SEQ_LOSS_CNT_EN
  output logic [7:0]           lock_loss_count,
  output logic [1:0]           seq_state
`else
  output logic [1:0]           seq_state
`endif
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;
  logic [LOCK_SYNC-1:0] sync_q, sync_d;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_end;
  logic [2:0] idx_q, idx_d;
  logic [N_DOMAINS-1:0] domain_reset_q, domain_reset_d, rel_mask;
  logic all_released_q, all_released_d;
  logic lock_s, last;
  assign sync_d   = {sync_q[LOCK_SYNC-2:0], pll_locked};
  assign lock_s   = sync_q[LOCK_SYNC-1];
  assign rel_mask = N_DOMAINS'(1) << idx_q;
  assign last     = idx_q == 3'(N_DOMAINS - 1);
  assign cnt_end  = state_q == HOLD ? CW'(HOLD_CYCLES - 1) : CW'(GAP_CYCLES - 1);
  // HOLD releases index 0, so HOLD and RELEASE share the same release step.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    domain_reset_d = domain_reset_q;
    all_released_d = all_released_q;
    if (state_q == WAIT_LOCK || !lock_s || sw_reset_req) begin
      state_d        = state_q == WAIT_LOCK ? (lock_s ? HOLD : WAIT_LOCK) : (!lock_s ? WAIT_LOCK : HOLD);
      cnt_d          = '0;
      idx_d          = '0;
      domain_reset_d = '1;
      all_released_d = 1'b0;
    end else if (state_q != RUN) begin
      if (cnt_q == cnt_end) begin
        cnt_d          = '0;
        idx_d          = idx_q + 3'd1;
        domain_reset_d = domain_reset_q & ~rel_mask;
        state_d        = last ? RUN : RELEASE;
        all_released_d = last;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q         <= '0;
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      idx_q          <= '0;
      domain_reset_q <= '1;
      all_released_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      domain_reset_q <= domain_reset_d;
      all_released_q <= all_released_d;
    end
  end
  assign domain_reset = domain_reset_q;
  assign all_released = all_released_q;
  assign seq_state    = state_q;
`ifdef RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;
  assign loss_cnt_d = (state_q != WAIT_LOCK && !lock_s && loss_cnt_q != 8'hff) ? loss_cnt_q + 8'd1 : loss_cnt_q;
  always_ff @(posedge clock) begin
    if (!reset_n) loss_cnt_q <= '0;
    else loss_cnt_q <= loss_cnt_d;
  end
  assign lock_loss_count = loss_cnt_q;
`endif
endmodule

// File: tb/tb_reset_sequencer_ctrl.sv
// tb_reset_sequencer_ctrl: scoreboard bench; a time-since-hold model predicts every cycle's outputs.
module tb_reset_sequencer_ctrl;
  localparam int N = 4;
  localparam int HOLD = 256;
  localparam int GAP = 16;
  localparam int LS = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic sw_reset_req = 1'b0;
  logic [N-1:0] domain_reset;
  logic all_released;
  logic [1:0] seq_state;
  logic [7:0] lc_dut;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [1:0]   st;
    logic [N-1:0] dr;
    logic         ar;
    logic [7:0]   lc;
  } exp_t;
  exp_t sb[$];
  reset_sequencer_ctrl #(.N_DOMAINS(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .LOCK_SYNC(LS)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .domain_reset(domain_reset),
    .all_released(all_released),
`ifdef RESET_SEQ_LOSS_CNT_EN
    .lock_loss_count(lc_dut),
`endif
    .seq_state(seq_state)
  );
`ifndef RESET_SEQ_LOSS_CNT_EN
  assign lc_dut = 8'd0;
`endif
  always #5 clock = ~clock;
  // Reference: lock seen LS edges late; outputs are a pure function of cycles elapsed since hold start.
  initial begin
    bit hist[$];
    bit active, ls;
    int t, rel, lcnt;
    exp_t e;
    active = 0; t = 0; lcnt = 0;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        hist.delete();
        for (int i = 0; i < LS; i++) hist.push_back(1'b0);
        active = 0; t = 0; lcnt = 0;
      end else begin
        ls = hist.pop_front();
        hist.push_back(pll_locked);
        if (!active) begin
          if (ls) begin active = 1; t = 0; end
        end else if (!ls) begin
          active = 0;
          if (lcnt < 255) lcnt++;
        end else if (sw_reset_req) t = 0;
        else if (t < HOLD + N * GAP) t++;
      end
      rel = !active || t < HOLD ? 0 : (t - HOLD) / GAP + 1;
      if (rel > N) rel = N;
      e.dr = '1;
      for (int k = 0; k < N; k++) if (k < rel) e.dr[k] = 1'b0;
      e.st = !active ? 2'd0 : rel == 0 ? 2'd1 : rel < N ? 2'd2 : 2'd3;
      e.ar = active && rel == N;
`ifdef RESET_SEQ_LOSS_CNT_EN
      e.lc = 8'(lcnt);
`else
      e.lc = 8'd0;
`endif
      sb.push_back(e);
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (seq_state !== e.st || domain_reset !== e.dr || all_released !== e.ar || lc_dut !== e.lc) begin
          failures++;
          if (failures <= 20)
            $display("FAIL outputs t=%0t got st=%0d dr=%b ar=%b lc=%0d expected st=%0d dr=%b ar=%b lc=%0d",
                     $time, seq_state, domain_reset, all_released, lc_dut, e.st, e.dr, e.ar, e.lc);
        end
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic pulse_sw();
    sw_reset_req = 1'b1;
    cyc(1);
    sw_reset_req = 1'b0;
  endtask
  initial begin
    int m;
    cyc(5);
    reset_n = 1'b1;
    cyc(2);
    pll_locked = 1'b1;
    cyc(320);
    pulse_sw();
    cyc(100);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(330);
    pulse_sw();
    cyc(280);
    pll_locked = 1'b0;
    cyc(6);
    pll_locked = 1'b1;
    cyc(330);
    pll_locked = 1'b0;
    cyc(2);
    pulse_sw();
    pll_locked = 1'b1;
    cyc(20);
    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 9);
      if (m == 0) begin
        reset_n = 1'b0;
        cyc($urandom_range(1, 3));
        reset_n = 1'b1;
      end else if (m <= 2) pulse_sw();
      else if (m <= 4) begin
        pll_locked = 1'b0;
        cyc($urandom_range(1, 6));
        pll_locked = 1'b1;
      end else cyc($urandom_range(1, 400));
    end
`ifdef RESET_SEQ_LOSS_CNT_EN
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      cyc(6);
      pll_locked = 1'b0;
      cyc(4);
    end
    pll_locked = 1'b1;
    cyc(10);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(5);
`endif
    cyc(3);
    if (sb.size() > 1) begin
      failures++;
      $display("FAIL drain pending=%0d expected<=1", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer_ctrl.md
Name: reset_sequencer_ctrl

Overview:
- Single-clock controller that sequences the reset release of up to N downstream clock domains on the FPGA shell.
- Waits for PLL lock, holds all domains in reset for a debounce period, then releases them one at a time in increasing index order with a fixed gap between releases.
- Re-asserts every domain reset immediately on lock loss or a software reset request.
- Outputs drive the async-reset inputs of the per-domain reset synchronizers.

Parameters:
- N_DOMAINS, 4, number of sequenced domain resets (1..8).
- HOLD_CYCLES, 256, consecutive locked cycles required before domain 0 releases (>=1).
- GAP_CYCLES, 16, cycles between successive domain releases (>=1).
- LOCK_SYNC, 2, synchronizer depth for pll_locked (>=2).

Ports:
- clock  in  1  controller clock (free-running reference clock, not PLL-derived).
- reset_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  asynchronous PLL lock indication; synchronized internally.
- sw_reset_req  in  1  single-cycle synchronous request to re-run the sequence.
- domain_reset  out  N_DOMAINS  active-high reset per domain; bit k releases k-th.
- all_released  out  1  high only while all domains are released (state RUN).
- seq_state  out  2  current state: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN.

Behaviour:
- Sync reset, or power-up initial values:
  - state WAIT_LOCK; domain_reset all ones; all_released 0.
  - counter 0; domain index 0; lock synchronizer flops 0.
- lock_s is pll_locked after LOCK_SYNC flops. All decisions use lock_s.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). All outputs are registered.
- WAIT_LOCK:
  - domain_reset all ones.
  - When lock_s=1, next state HOLD with counter cleared.
- HOLD:
  - Counter increments each cycle.
  - In the cycle where counter==HOLD_CYCLES-1 and lock_s=1: at the next edge, domain_reset[0]<=0, state<=RELEASE, counter<=0.
  - If N_DOMAINS==1, state goes straight to RUN instead.
  - Result: domain 0 is low from H+HOLD_CYCLES, where H is the first HOLD cycle.
- RELEASE:
  - Counter increments each cycle.
  - When counter==GAP_CYCLES-1: release the next index, clear the counter.
  - Domain k is therefore low from H+HOLD_CYCLES+k*GAP_CYCLES.
  - On the edge that releases domain N_DOMAINS-1: state<=RUN and all_released<=1.
- RUN:
  - Outputs held.
  - Exits only on lock loss or sw_reset_req.
- Lock loss (lock_s=0) in HOLD, RELEASE or RUN:
  - Next edge: domain_reset all ones, all_released 0, state WAIT_LOCK, counter 0, index 0.
- sw_reset_req=1 in HOLD, RELEASE or RUN with lock_s=1:
  - Next edge: domain_reset all ones, all_released 0, state HOLD, counter 0, index 0.
  - The full hold period is re-served.
- sw_reset_req in WAIT_LOCK is ignored.
- Simultaneous lock loss and sw_reset_req: lock loss wins (WAIT_LOCK).
- Released domains never re-release out of order: a domain bit goes 0 only in ascending index order after a full hold.
- Re-assertion is always all bits at once.
- Unused upper bits do not exist; the width is exactly N_DOMAINS.

Optional Feature:
- Macro: RESET_SEQ_LOSS_CNT_EN.
- With macro:
  - Adds output port lock_loss_count (8 bits).
  - Increments by 1 on every HOLD/RELEASE/RUN->WAIT_LOCK transition caused by lock loss.
  - Saturates at 255. Cleared only by reset_n.
  - sw_reset_req does not count.
- Without macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use defaults N_DOMAINS=4, HOLD_CYCLES=256, GAP_CYCLES=16, LOCK_SYNC=2.
1. reset_n low 5 cycles, then pll_locked rises -> seq_state goes 0->1 exactly 3 edges after the rise (H). domain_reset[0..3] fall at H+256, H+272, H+288, H+304. all_released=1 from H+304.
2. pll_locked drops 1 cycle at H+100 -> domain_reset stays 4'b1111. State returns to WAIT_LOCK. After relock, the hold restarts from count 0; domain 0 falls 256 cycles after the new H.
3. In RUN, pulse sw_reset_req -> next cycle domain_reset=4'b1111, all_released=0, seq_state=1. Re-release follows the same offsets as scenario 1 from the new H.
4. pll_locked drops at H+280 (domains 0 and 1 released) -> within LOCK_SYNC+1 cycles domain_reset=4'b1111 and seq_state=0. No partial pattern is ever observed.
5. sw_reset_req and lock loss reach the controller in the same cycle during RUN -> seq_state=0, not 1.
6. With RESET_SEQ_LOSS_CNT_EN, 300 lock-loss events from RUN -> lock_loss_count reads 255. reset_n low -> reads 0 and domain_reset=4'b1111 after one edge.
